// File: rtl/mem_stage_if.sv
// Debug dump handshake between mem_stage (slave) and the debug unit (master).
interface mem_stage_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              i_Dump_start;
  logic              i_Dump_ready;
  logic              o_Dump_valid;
  logic [ADDR_W-1:0] o_Dump_addr;
  logic [31:0]       o_Dump_data;
  logic              o_Dump_done;

  modport master (
    output i_Dump_start, i_Dump_ready,
    input  o_Dump_valid, o_Dump_addr, o_Dump_data, o_Dump_done
  );

  modport slave (
    input  i_Dump_start, i_Dump_ready,
    output o_Dump_valid, o_Dump_addr, o_Dump_data, o_Dump_done
  );
endinterface

// File: rtl/mem_stage.sv
// MEM stage: data memory with byte/half/word access, negedge MEM/WB register, dump FSM.
// Optional MEM_ALIGN_CHECK_EN: flag, suppress and zero misaligned half/word accesses.
module mem_stage #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       i_PC_Address,
  input  logic [31:0]       i_ALU_result,
  input  logic [DATA_W-1:0] i_Read_data_2,
  input  logic [4:0]        i_MuxRegDst_result,
  input  logic              i_RegWrite,
  input  logic [1:0]        i_MemtoReg,
  input  logic              i_Halt,
  input  logic              i_MemRead,
  input  logic              i_MemWrite,
  input  logic [1:0]        i_Long,
  input  logic              i_MemSign,
  output logic [31:0]       o_PC_Address,
  output logic [31:0]       o_ALU_result,
  output logic [DATA_W-1:0] o_Read_data,
  output logic [4:0]        o_MuxRegDst_result,
  output logic              o_RegWrite,
  output logic [1:0]        o_MemtoReg,
  output logic              o_Halt,
  output logic              o_Misaligned,
  mem_stage_if.slave        dump
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DUMP = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] widx_c;
  logic [1:0]        off_c;
  logic [DATA_W-1:0] rd_word_c;
  logic [7:0]        byte_c;
  logic [15:0]       half_c;
  logic [DATA_W-1:0] load_c;
  logic [3:0]        be_c;
  logic [DATA_W-1:0] wdata_c;
  logic              misalign_c;

  assign widx_c    = i_ALU_result[ADDR_W+1:2];
  assign off_c     = i_ALU_result[1:0];
  assign rd_word_c = mem_q[widx_c];
  assign byte_c    = rd_word_c[{off_c, 3'b000} +: 8];
  assign half_c    = rd_word_c[{off_c[1], 4'b0000} +: 16];

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_c = (i_MemRead | i_MemWrite) &
                      (((i_Long == 2'b01) & off_c[0]) | (i_Long[1] & (off_c != 2'b00)));
`else
  assign misalign_c = 1'b0;
`endif

  // Lane enables and lane-replicated store data
  always_comb begin
    be_c    = 4'hF;
    wdata_c = i_Read_data_2;
    case (i_Long)
      2'b00: begin
        be_c    = 4'(4'b0001 << off_c);
        wdata_c = {4{i_Read_data_2[7:0]}};
      end
      2'b01: begin
        be_c    = off_c[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{i_Read_data_2[15:0]}};
      end
      default: begin
        be_c    = 4'hF;
        wdata_c = i_Read_data_2;
      end
    endcase
  end

  // Load extraction and extension
  always_comb begin
    load_c = '0;
    case (i_Long)
      2'b00:   load_c = i_MemSign ? {{24{byte_c[7]}}, byte_c}  : {24'h0, byte_c};
      2'b01:   load_c = i_MemSign ? {{16{half_c[15]}}, half_c} : {16'h0, half_c};
      default: load_c = rd_word_c;
    endcase
    if (!i_MemRead || misalign_c) begin
      load_c = '0;
    end
  end

  // Store lands on posedge, after the negedge load capture of the same slot
  always_ff @(posedge clk) begin
    if (!rst && i_MemWrite && !misalign_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) begin
          mem_q[widx_c][8*i +: 8] <= wdata_c[8*i +: 8];
        end
      end
    end
  end

  // MEM/WB pipeline register
  always_ff @(negedge clk) begin
    if (rst) begin
      o_PC_Address       <= '0;
      o_ALU_result       <= '0;
      o_Read_data        <= '0;
      o_MuxRegDst_result <= '0;
      o_RegWrite         <= 1'b0;
      o_MemtoReg         <= '0;
      o_Halt             <= 1'b0;
      o_Misaligned       <= 1'b0;
    end else begin
      o_PC_Address       <= i_PC_Address;
      o_ALU_result       <= i_ALU_result;
      o_Read_data        <= load_c;
      o_MuxRegDst_result <= i_MuxRegDst_result;
      o_RegWrite         <= i_RegWrite;
      o_MemtoReg         <= i_MemtoReg;
      o_Halt             <= i_Halt;
      o_Misaligned       <= misalign_c;
    end
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (dump.i_Dump_start) begin
          state_d = ST_DUMP;
          idx_d   = '0;
        end
      end
      ST_DUMP: begin
        if (dump.i_Dump_ready) begin
          idx_d = ADDR_W'(idx_q + 1'b1);
          if (idx_q == {ADDR_W{1'b1}}) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Data follows memory live, so a same-cycle store shows up once it lands
  always_comb begin
    dump.o_Dump_valid = 1'b0;
    dump.o_Dump_done  = 1'b0;
    dump.o_Dump_addr  = idx_q;
    dump.o_Dump_data  = mem_q[idx_q];
    case (state_q)
      ST_DUMP: dump.o_Dump_valid = 1'b1;
      ST_DONE: dump.o_Dump_done  = 1'b1;
      default: ;
    endcase
  end

endmodule
